// File: rtl/debug_types.sv
// debug_types: shared types for the abstract-command engine.
//   state_e  - command FSM states
//   ERR_*    - abstractcs.cmderr codes
//   cmd_t    - field view of an access-register command word
//   *_LO/HI  - regno windows for CSRs and GPRs
package debug_types;
  typedef enum logic [2:0] {ST_IDLE, ST_CHECK, ST_REQ, ST_WAIT, ST_DONE} state_e;
  localparam logic [2:0] ERR_NONE   = 3'd0;
  localparam logic [2:0] ERR_BUSY   = 3'd1;
  localparam logic [2:0] ERR_NOTSUP = 3'd2;
  localparam logic [2:0] ERR_EXC    = 3'd3;
  localparam logic [2:0] ERR_HALT   = 3'd4;
  typedef struct packed {
    logic [7:0]  cmdtype;
    logic        rsvd;
    logic [2:0]  aarsize;
    logic        postinc;
    logic        postexec;
    logic        transfer;
    logic        write;
    logic [15:0] regno;
  } cmd_t;
  localparam logic [15:0] CSR_LO = 16'h0000;
  localparam logic [15:0] CSR_HI = 16'h0fff;
  localparam logic [15:0] GPR_LO = 16'h1000;
  localparam logic [15:0] GPR_HI = 16'h101f;
  localparam logic [2:0]  AARSIZE_32 = 3'd2;
endpackage

// File: rtl/dbg_timeout_ctr.sv
// dbg_timeout_ctr: counts wait cycles for a bus acknowledge.
//   clk, rst_n - clock, async active-low reset
//   start      - restart the count at zero (cycle before waiting begins)
//   tick       - a waiting cycle
//   expired    - this waiting cycle is the last one allowed (TIMEOUT-th)
module dbg_timeout_ctr #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic tick,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT + 1);
  logic [W-1:0] cnt_q, cnt_d;
  assign expired = tick && (cnt_q == W'(TIMEOUT - 1));
  always_comb cnt_d = start ? '0 : (tick && !expired) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/debug_abstract_cmd.sv
// debug_abstract_cmd: RISC-V debug-module abstract access-register command engine.
//   iClk/iRst_n           - clock, async active-low reset
//   iCmdValid/iCmd        - command register write
//   iHalted, iCmdErrClr   - hart halted, W1C mask for cmderr
//   iData0/oData0We/oData0 - data0 source for writes, load pulse for reads
//   oBusy/oCmdErr         - abstractcs.busy / cmderr
//   oCmdUpd/oCmdNext      - postincrement rewrite of the command register
//   oRf*/iRf*             - GPR access port
//   oCsr*/iCsr*           - CSR access port
module debug_abstract_cmd
  import debug_types::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        iClk,
  input  logic        iRst_n,
  input  logic        iCmdValid,
  input  logic [31:0] iCmd,
  input  logic        iHalted,
  input  logic [2:0]  iCmdErrClr,
  input  logic [31:0] iData0,
  output logic        oBusy,
  output logic [2:0]  oCmdErr,
  output logic        oData0We,
  output logic [31:0] oData0,
  output logic        oCmdUpd,
  output logic [31:0] oCmdNext,
  output logic        oRfReq,
  output logic        oRfWe,
  output logic [4:0]  oRfAddr,
  output logic [31:0] oRfWdata,
  input  logic        iRfAck,
  input  logic [31:0] iRfRdata,
  output logic        oCsrReq,
  output logic        oCsrWe,
  output logic [11:0] oCsrAddr,
  output logic [31:0] oCsrWdata,
  input  logic        iCsrAck,
  input  logic        iCsrErr,
  input  logic [31:0] iCsrRdata
);
  state_e     state_q, state_d;
  cmd_t       cmd_q, cmd_d;
  logic [2:0] cmderr_q, cmderr_d;
  logic       fail_q, fail_d;
  logic [2:0] own_err, err_code;
  logic       accept, is_csr, in_range, unsup, ack, ack_err, expired;
  assign accept   = (state_q == ST_IDLE) && iCmdValid && (cmderr_q == ERR_NONE);
  assign is_csr   = cmd_q.regno <= CSR_HI;
  assign in_range = is_csr || (cmd_q.regno >= GPR_LO && cmd_q.regno <= GPR_HI);
  assign unsup    = (cmd_q.cmdtype != 8'd0) || cmd_q.postexec ||
                    (cmd_q.transfer && (cmd_q.aarsize != AARSIZE_32 || !in_range));
  assign ack      = is_csr ? iCsrAck : iRfAck;
  assign ack_err  = is_csr && iCsrAck && iCsrErr;
  dbg_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk    (iClk),
    .rst_n  (iRst_n),
    .start  (state_q == ST_REQ),
    .tick   (state_q == ST_WAIT),
    .expired(expired)
  );
  always_ff @(posedge iClk or negedge iRst_n)
    if (!iRst_n) begin
      state_q  <= ST_IDLE;
      cmd_q    <= '0;
      cmderr_q <= ERR_NONE;
      fail_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      cmderr_q <= cmderr_d;
      fail_q   <= fail_d;
    end
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  state_d = accept ? ST_CHECK : ST_IDLE;
      ST_CHECK: state_d = (unsup || !cmd_q.transfer || !iHalted) ? ST_DONE : ST_REQ;
      ST_REQ:   state_d = ST_WAIT;
      ST_WAIT:  state_d = (ack || expired) ? ST_DONE : ST_WAIT;
      default:  state_d = ST_IDLE;
    endcase
  end
  // The running command's own error outranks a busy-write error in the same
  // cycle; fail_q remembers the own error so DONE can suppress postincrement.
  always_comb begin
    own_err  = (state_q == ST_CHECK) ? (unsup ? ERR_NOTSUP : (cmd_q.transfer && !iHalted) ? ERR_HALT : ERR_NONE) :
               (state_q == ST_WAIT)  ? ((ack ? ack_err : expired) ? ERR_EXC : ERR_NONE) : ERR_NONE;
    err_code = (own_err != ERR_NONE) ? own_err :
               (state_q != ST_IDLE && iCmdValid) ? ERR_BUSY : ERR_NONE;
    cmderr_d = (cmderr_q == ERR_NONE && err_code != ERR_NONE) ? err_code : cmderr_q & ~iCmdErrClr;
    fail_d   = (state_q == ST_IDLE) ? 1'b0 : fail_q | (own_err != ERR_NONE);
    cmd_d    = accept ? cmd_t'(iCmd) : cmd_q;
  end
  always_comb begin
    oBusy     = state_q != ST_IDLE;
    oCmdErr   = cmderr_q;
    oCsrReq   = (state_q == ST_REQ) && is_csr;
    oRfReq    = (state_q == ST_REQ) && !is_csr;
    oCsrWe    = oCsrReq && cmd_q.write;
    oRfWe     = oRfReq && cmd_q.write;
    oCsrAddr  = cmd_q.regno[11:0];
    oRfAddr   = cmd_q.regno[4:0];
    oCsrWdata = iData0;
    oRfWdata  = iData0;
    oData0We  = (state_q == ST_WAIT) && ack && !ack_err && !cmd_q.write;
    oData0    = is_csr ? iCsrRdata : iRfRdata;
    oCmdUpd   = (state_q == ST_DONE) && cmd_q.postinc && cmd_q.transfer && !fail_q;
    oCmdNext  = {cmd_q[31:16], cmd_q.regno + 16'd1};
  end
endmodule

// File: tb/tb_debug_abstract_cmd.sv
// tb_debug_abstract_cmd: directed and randomized checks of the abstract-command engine.
module tb_debug_abstract_cmd;
  localparam int TO = 16;
  logic        iClk = 1'b0, iRst_n = 1'b0, iCmdValid = 1'b0, iHalted = 1'b0;
  logic        iRfAck = 1'b0, iCsrAck = 1'b0, iCsrErr = 1'b0;
  logic [31:0] iCmd = '0, iData0 = '0, iRfRdata = '0, iCsrRdata = '0;
  logic [2:0]  iCmdErrClr = '0;
  logic        oBusy, oData0We, oCmdUpd, oRfReq, oRfWe, oCsrReq, oCsrWe;
  logic [2:0]  oCmdErr;
  logic [31:0] oData0, oCmdNext, oRfWdata, oCsrWdata;
  logic [4:0]  oRfAddr;
  logic [11:0] oCsrAddr;
  int checks = 0, failures = 0;
  always #5 iClk = ~iClk;
  debug_abstract_cmd #(.TIMEOUT(TO)) dut (
    .iClk(iClk), .iRst_n(iRst_n), .iCmdValid(iCmdValid), .iCmd(iCmd),
    .iHalted(iHalted), .iCmdErrClr(iCmdErrClr), .iData0(iData0),
    .oBusy(oBusy), .oCmdErr(oCmdErr), .oData0We(oData0We), .oData0(oData0),
    .oCmdUpd(oCmdUpd), .oCmdNext(oCmdNext),
    .oRfReq(oRfReq), .oRfWe(oRfWe), .oRfAddr(oRfAddr), .oRfWdata(oRfWdata),
    .iRfAck(iRfAck), .iRfRdata(iRfRdata),
    .oCsrReq(oCsrReq), .oCsrWe(oCsrWe), .oCsrAddr(oCsrAddr), .oCsrWdata(oCsrWdata),
    .iCsrAck(iCsrAck), .iCsrErr(iCsrErr), .iCsrRdata(iCsrRdata)
  );
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask
  task automatic clear_err();
    @(negedge iClk);
    iCmdErrClr = 3'h7;
    @(negedge iClk);
    iCmdErrClr = 3'h0;
    #1 check("cmderr_cleared", oCmdErr, 0);
  endtask
  // Issues one command and follows it to completion. d: cycles from the request
  // to the acknowledge; cerr: CSR answers with an error; inj: cycle (after
  // acceptance) at which a second command write arrives, 0 for none.
  task automatic run_cmd(input logic [31:0] cmd, input bit halted, input int d, input bit cerr,
                         input int inj, input logic [31:0] rd, input logic [31:0] d0);
    logic [15:0] regno;
    bit transfer, write, postinc, postexec, csr, unsup, req, load, upd, hit;
    int own, exp_err, exp_busy;
    int busy, reqs, loads, upds, req_cyc, k;
    bit got_csr, got_we;
    logic [31:0] got_addr, got_wd, got_d0, got_next;
    regno    = cmd[15:0];
    transfer = cmd[17];
    write    = cmd[16];
    postinc  = cmd[19];
    postexec = cmd[18];
    csr      = regno < 16'h1000;
    unsup    = cmd[31:24] != 8'd0 || postexec || (transfer && (cmd[22:20] != 3'd2 || regno >= 16'h1020));
    own      = unsup ? 2 : (transfer && !halted) ? 4 : !transfer ? 0 : d > TO ? 3 : (csr && cerr) ? 3 : 0;
    req      = transfer && !unsup && halted;
    exp_busy = req ? 3 + (d > TO ? TO : d) : 2;
    exp_err  = (own == 2 || own == 4) ? own : (inj != 0) ? 1 : own;
    load     = req && !write && own == 0;
    upd      = postinc && transfer && own == 0;
    iHalted   = halted;
    iData0    = d0;
    iCsrRdata = csr ? rd : ~rd;
    iRfRdata  = csr ? ~rd : rd;
    @(negedge iClk);
    iCmdValid = 1'b1;
    iCmd      = cmd;
    busy = 0; reqs = 0; loads = 0; upds = 0; req_cyc = -1; k = 0;
    got_csr = 0; got_we = 0; got_addr = '0; got_wd = '0; got_d0 = '0; got_next = '0;
    do begin
      @(negedge iClk);
      k++;
      iCmdValid = (k == inj);
      iCmd      = $urandom;
      hit       = req_cyc >= 0 && (k - req_cyc) == d;
      iCsrAck   = hit && csr;
      iRfAck    = hit && !csr;
      iCsrErr   = hit && csr && cerr;
      #1;
      if (oBusy) busy++;
      if (oCsrReq || oRfReq) begin
        reqs++;
        req_cyc  = k;
        got_csr  = oCsrReq;
        got_addr = oCsrReq ? 32'(oCsrAddr) : 32'(oRfAddr);
        got_we   = oCsrReq ? oCsrWe : oRfWe;
        got_wd   = oCsrReq ? oCsrWdata : oRfWdata;
      end
      if (oData0We) begin
        loads++;
        got_d0 = oData0;
      end
      if (oCmdUpd) begin
        upds++;
        got_next = oCmdNext;
      end
    end while (oBusy && k < 100);
    iCmdValid = 1'b0; iCsrAck = 1'b0; iRfAck = 1'b0; iCsrErr = 1'b0;
    check("busy_cycles", busy, exp_busy);
    check("cmderr", oCmdErr, exp_err);
    check("req_count", reqs, req);
    if (reqs == 1 && req) begin
      check("req_is_csr", got_csr, csr);
      check("req_addr", got_addr, csr ? 32'(regno[11:0]) : 32'(regno[4:0]));
      check("req_we", got_we, write);
      check("req_wdata", got_wd, d0);
    end
    check("data0_loads", loads, load);
    if (loads == 1 && load) check("data0_value", got_d0, rd);
    check("upd_count", upds, upd);
    if (upds == 1 && upd) check("cmd_next", got_next, {cmd[31:16], regno + 16'd1});
  endtask
  initial begin
    logic [31:0] c;
    logic [15:0] rn;
    int sel;
    repeat (2) @(negedge iClk);
    #1;
    check("rst_busy", oBusy, 0);
    check("rst_cmderr", oCmdErr, 0);
    check("rst_reqs", {oRfReq, oCsrReq, oRfWe, oCsrWe}, 0);
    check("rst_pulses", {oData0We, oCmdUpd}, 0);
    @(negedge iClk);
    iRst_n = 1'b1;
    // GPR read of x0 with acknowledge two cycles after the request
    run_cmd(32'h00221000, 1, 2, 0, 0, 32'hDEADBEEF, 32'h0);
    // CSR write to mstatus
    run_cmd(32'h00230300, 1, 1, 0, 0, 32'h12345678, 32'h8);
    // Timeout, then a write is ignored while cmderr is set
    run_cmd(32'h00221001, 1, TO + 5, 0, 0, 32'h0, 32'h0);
    @(negedge iClk);
    iCmdValid = 1'b1;
    iCmd      = 32'h00221000;
    @(negedge iClk);
    iCmdValid = 1'b0;
    #1 check("ignored_busy", oBusy, 0);
    check("ignored_err", oCmdErr, 3);
    iCmdErrClr = 3'h1;
    @(negedge iClk);
    iCmdErrClr = 3'h0;
    #1 check("partial_clear", oCmdErr, 2);
    clear_err();
    // Postincrement, then an out-of-range regno
    run_cmd(32'h002A1005, 1, 1, 0, 0, 32'hCAFEF00D, 32'h0);
    run_cmd(32'h00221020, 1, 1, 0, 0, 32'h0, 32'h0);
    clear_err();
    // Running hart, then a busy write during WAIT
    run_cmd(32'h00221000, 0, 1, 0, 0, 32'h0, 32'h0);
    clear_err();
    run_cmd(32'h00221000, 1, 4, 0, 4, 32'hA5A5A5A5, 32'h0);
    clear_err();
    // CSR bus error on a read
    run_cmd(32'h00220341, 1, 3, 1, 0, 32'h55AA55AA, 32'h0);
    clear_err();
    // Reset in the middle of WAIT with an acknowledge present
    @(negedge iClk);
    iHalted   = 1'b1;
    iCmdValid = 1'b1;
    iCmd      = 32'h00221001;
    @(negedge iClk);
    iCmdValid = 1'b0;
    repeat (3) @(negedge iClk);
    #1 check("pre_rst_busy", oBusy, 1);
    iRfAck = 1'b1;
    iRst_n = 1'b0;
    #1;
    check("midrst_busy", oBusy, 0);
    check("midrst_rfreq", oRfReq, 0);
    check("midrst_load", oData0We, 0);
    check("midrst_err", oCmdErr, 0);
    @(negedge iClk);
    iRfAck = 1'b0;
    iRst_n = 1'b1;
    run_cmd(32'h00231002, 1, 1, 0, 0, 32'h0, 32'h77);
    // Randomized commands
    for (int n = 0; n < 60; n++) begin
      sel = $urandom_range(0, 9);
      rn  = (sel < 4) ? 16'($urandom_range(0, 16'h0fff)) :
            (sel < 8) ? 16'h1000 + 16'($urandom_range(0, 31)) :
            (sel < 9) ? 16'h1020 + 16'($urandom_range(0, 255)) : 16'hffff;
      c = {($urandom_range(0, 9) == 0) ? 8'($urandom_range(1, 255)) : 8'h00, 1'b0,
           ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'd2,
           1'($urandom), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 7) != 0), 1'($urandom), rn};
      run_cmd(c, $urandom_range(0, 4) != 0, $urandom_range(1, TO + 2),
              $urandom_range(0, 3) == 0, ($urandom_range(0, 4) == 0) ? 2 : 0,
              $urandom, $urandom);
      clear_err();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/debug_abstract_cmd.md
DEBUG_ABSTRACT_CMD -- requirements
Module: debug_abstract_cmd

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, the maximum number of cycles to wait for a bus acknowledge.
REQ-002 SHALL have ports iClk (in, 1, clock) and iRst_n (in, 1, reset); the block uses one clock, and reset is asynchronous and active-low.
REQ-003 SHALL have ports iCmdValid (in, 1, command-register write pulse) and iCmd (in, 32, command word).
REQ-004 SHALL have ports iHalted (in, 1, hart halted), iCmdErrClr (in, 3, write-1-to-clear mask for cmderr) and iData0 (in, 32, current data0).
REQ-005 SHALL have outputs oBusy (1, abstractcs.busy), oCmdErr (3, abstractcs.cmderr), oData0We (1, data0 load pulse) and oData0 (32, load value).
REQ-006 SHALL have outputs oCmdUpd (1, command rewrite pulse) and oCmdNext (32, command with regno+1).
REQ-007 SHALL have GPR port oRfReq (out, 1), oRfWe (out, 1), oRfAddr (out, 5), oRfWdata (out, 32), iRfAck (in, 1) and iRfRdata (in, 32).
REQ-008 SHALL have CSR port oCsrReq (out, 1), oCsrWe (out, 1), oCsrAddr (out, 12), oCsrWdata (out, 32), iCsrAck (in, 1), iCsrErr (in, 1) and iCsrRdata (in, 32).

Function
REQ-009 SHALL implement FSM IDLE -> CHECK -> REQ -> WAIT -> DONE -> IDLE, with oBusy=1 in every state except IDLE.
REQ-010 SHALL accept the command in IDLE on iCmdValid only when oCmdErr==0; the command is latched, and oBusy rises on the next cycle.
REQ-011 SHALL ignore iCmdValid in IDLE when oCmdErr!=0, with no state change.
REQ-012 SHALL set oCmdErr=1 (busy) on iCmdValid while oBusy=1 and oCmdErr==0, and the running command SHALL continue.
REQ-013 SHALL, in CHECK, decode the command fields: cmdtype[31:24], aarsize[22:20], postinc[19], postexec[18], transfer[17], write[16] and regno[15:0].
REQ-014 SHALL set cmderr=2 (not supported) and go to DONE when cmdtype!=0, or postexec=1, or (transfer=1 and aarsize!=2), or (transfer=1 and regno outside 0x0000-0x0FFF/0x1000-0x101F).
REQ-015 SHALL set cmderr=4 (halt/resume) and go to DONE when transfer=1 and iHalted=0.
REQ-016 SHALL go directly from CHECK to DONE with success when transfer=0.
REQ-017 SHALL, in REQ, assert the selected request for exactly one cycle: CSR for regno<0x1000 with addr=regno[11:0], GPR otherwise with addr=regno[4:0]; We=write and Wdata=iData0.
REQ-018 SHALL, in WAIT, complete on Ack: a read pulses oData0We with the returned rdata; iCsrErr together with iCsrAck SHALL give cmderr=3 and no data0 load.
REQ-019 SHALL, in WAIT, set cmderr=3 and go to DONE when no Ack arrives within TIMEOUT cycles of entering WAIT.
REQ-020 SHALL ignore an Ack arriving in any state other than WAIT.
REQ-021 SHALL, in DONE, pulse oCmdUpd with oCmdNext = iCmd-latched with regno+1 (16-bit wrap, 0xFFFF->0x0000) when postinc=1, transfer=1 and no error; DONE SHALL last one cycle.
REQ-022 SHALL make an error recorded by REQ-014/015/018/019 set oCmdErr only if oCmdErr==0; the first error sticks.
REQ-023 SHALL clear the oCmdErr bits set in iCmdErrClr each cycle; a same-cycle set takes priority over the clear.

Reset
REQ-024 SHALL, on iRst_n=0, put the FSM in IDLE, drive oBusy, oCmdErr, every Req/We pulse, oCmdUpd and the timeout counter to 0, and clear the latched command.
REQ-025 SHALL, on reset asserted mid-transaction, drop any request immediately, with no data0 load.

Structure
REQ-026 SHALL place the state enum, the cmderr codes, the command-field struct and the regno range constants in the shared debug_types package.
REQ-027 SHALL place the timeout counter in a sub-module dbg_timeout_ctr with ports start, tick and expired.

Verification
REQ-028 SHALL cover: halted, iCmd=0x00221000 (read x0), iRfRdata=0xDEADBEEF, ack after 2 cycles -> oData0We pulse with 0xDEADBEEF, oBusy high for 5 cycles, cmderr=0.
REQ-029 SHALL cover: halted, iCmd=0x00230300 (write mstatus), iData0=0x8 -> oCsrReq one cycle, addr=0x300, We=1, Wdata=0x8.
REQ-030 SHALL cover: iCmd=0x00221001, ack idle for TIMEOUT cycles -> cmderr=3; a following iCmdValid is ignored until iCmdErrClr=0x7.
REQ-031 SHALL cover: iCmd=0x002A1005 (postinc) -> oCmdNext=0x002A1006; iCmd=0x00221020 -> cmderr=2 and no request.
REQ-032 SHALL cover: running hart, iCmd=0x00221000 -> cmderr=4; iCmdValid during WAIT -> cmderr=1 and the original access still completes.
REQ-033 SHALL cover: iRst_n low during WAIT -> oBusy=0 and oRfReq=0 within the same cycle.
